gpio_pad_input_filter: RTL and testbench

Conditions GPIO input signals that arrive from the bidirectional pad cells' core-side `C` outputs before they reach the SoC GPIO peripheral. For each pin it provides:
- a two-flop synchronizer
- a programmable per-pin debounce filter
- edge or level event detection with sticky pending flags

It sits between the pad ring and the GPIO input/interrupt logic, and is the receive-direction counterpart of the pad output/enable drive.

---
 rtl/gpio_pad_input_filter_if.sv | 29 ++
 rtl/gpio_pad_input_filter.sv | 82 ++++++++
 tb/tb_gpio_pad_input_filter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_input_filter_if.sv
// Signal bundle between the GPIO input-conditioning block and its controller:
// pad-side inputs, per-pin filter/event configuration, and filtered results.
interface gpio_pad_input_filter_if #(
    parameter int NUM_PINS  = 11,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_PINS-1:0]   pad_c_i;
    logic [NUM_PINS-1:0]   pad_ie_i;
    logic [NUM_PINS-1:0]   filt_en_i;
    logic [CNT_WIDTH-1:0]  debounce_limit_i;
    logic [2*NUM_PINS-1:0] irq_type_i;
    logic [NUM_PINS-1:0]   irq_en_i;
    logic [NUM_PINS-1:0]   irq_clr_i;
    logic [NUM_PINS-1:0]   gpio_in_o;
    logic [NUM_PINS-1:0]   irq_pending_o;
    logic                  irq_o;

    modport master (
        output pad_c_i, pad_ie_i, filt_en_i, debounce_limit_i,
               irq_type_i, irq_en_i, irq_clr_i,
        input  gpio_in_o, irq_pending_o, irq_o
    );

    modport slave (
        input  pad_c_i, pad_ie_i, filt_en_i, debounce_limit_i,
               irq_type_i, irq_en_i, irq_clr_i,
        output gpio_in_o, irq_pending_o, irq_o
    );
endinterface

// File: rtl/gpio_pad_input_filter.sv
// Per-pin GPIO input conditioning: 2-flop synchronizer, programmable debounce,
// and edge/level event detection feeding sticky pending flags.
module gpio_pad_input_filter #(
    parameter int NUM_PINS  = 11,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpio_pad_input_filter_if.slave bus
);
    typedef enum logic [1:0] {
        IRQ_RISE  = 2'b00,
        IRQ_FALL  = 2'b01,
        IRQ_BOTH  = 2'b10,
        IRQ_LEVEL = 2'b11
    } irq_type_e;

    logic [NUM_PINS-1:0]  r_s1;
    logic [NUM_PINS-1:0]  r_s;
    logic [NUM_PINS-1:0]  r_f;
    logic [NUM_PINS-1:0]  r_pending;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_PINS];

    logic [NUM_PINS-1:0]  w_f_next;
    logic [NUM_PINS-1:0]  w_event;
    logic [NUM_PINS-1:0]  w_pending_next;
    logic [CNT_WIDTH-1:0] w_cnt_next [NUM_PINS];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_f_next   = r_f;
        w_cnt_next = r_cnt;
        w_event    = '0;
        for (int k = 0; k < NUM_PINS; k++) begin
            if (bus.pad_ie_i[k]) begin
                if (!bus.filt_en_i[k]) begin
                    w_f_next[k]   = r_s[k];
                    w_cnt_next[k] = '0;
                end else if (r_s[k] == r_f[k]) begin
                    w_cnt_next[k] = '0;
                end else if (r_cnt[k] >= bus.debounce_limit_i) begin
                    // ">=" lets a lowered limit accept on the very next edge.
                    w_f_next[k]   = r_s[k];
                    w_cnt_next[k] = '0;
                end else begin
                    w_cnt_next[k] = r_cnt[k] + CNT_WIDTH'(1);
                end

                case (irq_type_e'(bus.irq_type_i[2*k +: 2]))
                    IRQ_RISE:  w_event[k] = w_f_next[k] & ~r_f[k];
                    IRQ_FALL:  w_event[k] = ~w_f_next[k] & r_f[k];
                    IRQ_BOTH:  w_event[k] = w_f_next[k] ^ r_f[k];
                    IRQ_LEVEL: w_event[k] = w_f_next[k];
                    default:   w_event[k] = 1'b0;
                endcase
            end
        end
        // Set has priority over a same-edge clear.
        w_pending_next = (r_pending & ~bus.irq_clr_i) | (bus.irq_en_i & w_event);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s       <= '0;
            r_f       <= '0;
            r_pending <= '0;
            r_cnt     <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_s1      <= bus.pad_c_i;
            r_s       <= r_s1;
            r_f       <= w_f_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign bus.gpio_in_o     = r_f;
    assign bus.irq_pending_o = r_pending;
    assign bus.irq_o         = |r_pending;
endmodule

// File: tb/tb_gpio_pad_input_filter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a run-length behavioural model.
module tb_gpio_pad_input_filter;
    localparam int NP = 11;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpio_pad_input_filter_if #(.NUM_PINS(NP), .CNT_WIDTH(CW)) bus ();

    gpio_pad_input_filter #(.NUM_PINS(NP), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pad history for the 2-cycle sync delay, and a count of
    // consecutive cycles the synchronized level disagrees with the accepted one.
    logic [NP-1:0] hist[$];
    logic [NP-1:0] m_f;
    logic [NP-1:0] m_pend;
    int            m_run [NP];

    task automatic model_reset();
        hist = {};
        hist.push_back('0);
        hist.push_back('0);
        m_f    = '0;
        m_pend = '0;
        foreach (m_run[k]) m_run[k] = 0;
    endtask

    task automatic model_step();
        logic [NP-1:0] s;
        logic old, nf, ev;
        int lim;
        hist.push_front(bus.pad_c_i);
        s = hist[2];
        void'(hist.pop_back());
        for (int k = 0; k < NP; k++) begin
            old = m_f[k];
            nf  = old;
            ev  = 1'b0;
            if (bus.pad_ie_i[k]) begin
                lim = bus.filt_en_i[k] ? int'(bus.debounce_limit_i) : 0;
                if (s[k] != old) begin
                    m_run[k]++;
                    if (m_run[k] > lim) begin
                        nf       = s[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                case (bus.irq_type_i[2*k +: 2])
                    2'b00:   ev = nf & ~old;
                    2'b01:   ev = ~nf & old;
                    2'b10:   ev = nf ^ old;
                    default: ev = nf;
                endcase
            end
            m_pend[k] = (m_pend[k] & ~bus.irq_clr_i[k]) | (bus.irq_en_i[k] & ev);
            m_f[k]    = nf;
        end
    endtask

    // One clock: model advances on the inputs the DUT will sample, outputs checked on negedge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("gpio_in", 32'(bus.gpio_in_o), 32'(m_f));
        check("pending", 32'(bus.irq_pending_o), 32'(m_pend));
        check("irq", 32'(bus.irq_o), 32'(|m_pend));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_all();
        bus.irq_clr_i = '1;
        step();
        bus.irq_clr_i = '0;
    endtask

    task automatic set_type(input int k, input logic [1:0] t);
        bus.irq_type_i[2*k +: 2] = t;
    endtask

    task automatic pulse3(input int width, output int rise_at);
        rise_at = 0;
        for (int i = 1; i <= 14; i++) begin
            bus.pad_c_i[3] = (i <= width);
            step();
            if (bus.gpio_in_o[3] && rise_at == 0) rise_at = i;
        end
    endtask

    initial begin
        int rise_at;
        logic seen;

        // Reset with pads all high.
        bus.pad_c_i          = '1;
        bus.pad_ie_i         = '1;
        bus.filt_en_i        = '0;
        bus.debounce_limit_i = '0;
        bus.irq_type_i       = '0;
        bus.irq_en_i         = '1;
        bus.irq_clr_i        = '0;
        rst_n                = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gpio", 32'(bus.gpio_in_o), 32'h0);
        check("rst_pend", 32'(bus.irq_pending_o), 32'h0);
        check("rst_irq", 32'(bus.irq_o), 32'h0);
        rst_n = 1'b1;
        step();
        check("lat_e0", 32'(bus.gpio_in_o[0]), 32'h0);
        step();
        check("lat_e1", 32'(bus.gpio_in_o[0]), 32'h0);
        step();
        check("lat_e2_gpio", 32'(bus.gpio_in_o[0]), 32'h1);
        check("lat_e2_pend", 32'(bus.irq_pending_o[0]), 32'h1);
        check("lat_e2_irq", 32'(bus.irq_o), 32'h1);

        // Debounce reject / accept on pin 3 with L = 4.
        bus.pad_c_i = '0;
        steps(4);
        clear_all();
        bus.filt_en_i[3]     = 1'b1;
        bus.debounce_limit_i = 8'd4;
        pulse3(4, rise_at);
        check("deb4_reject", 32'(rise_at), 32'd0);
        check("deb4_nopend", 32'(bus.irq_pending_o[3]), 32'h0);
        pulse3(5, rise_at);
        check("deb5_accept_at", 32'(rise_at), 32'd7);
        clear_all();

        // Lowering the limit mid-count accepts on the next edge.
        bus.debounce_limit_i = 8'd200;
        bus.pad_c_i[3]       = 1'b1;
        steps(12);
        check("l200_hold", 32'(bus.gpio_in_o[3]), 32'h0);
        bus.debounce_limit_i = 8'd2;
        step();
        check("l_lowered", 32'(bus.gpio_in_o[3]), 32'h1);
        bus.pad_c_i[3] = 1'b0;
        steps(8);
        clear_all();
        bus.filt_en_i[3]     = 1'b0;
        bus.debounce_limit_i = '0;

        // Edge types on pin 5.
        set_type(5, 2'b01);
        bus.pad_c_i[5] = 1'b1;
        steps(4);
        check("fall_norise", 32'(bus.irq_pending_o[5]), 32'h0);
        bus.pad_c_i[5] = 1'b0;
        steps(4);
        check("fall_set", 32'(bus.irq_pending_o[5]), 32'h1);
        clear_all();
        check("fall_clr", 32'(bus.irq_pending_o[5]), 32'h0);
        set_type(5, 2'b10);
        bus.pad_c_i[5] = 1'b1;
        steps(4);
        check("both_rise", 32'(bus.irq_pending_o[5]), 32'h1);
        clear_all();
        bus.pad_c_i[5] = 1'b0;
        steps(4);
        check("both_fall", 32'(bus.irq_pending_o[5]), 32'h1);
        clear_all();
        set_type(5, 2'b11);
        bus.pad_c_i[5] = 1'b1;
        steps(4);
        check("lvl_set", 32'(bus.irq_pending_o[5]), 32'h1);
        bus.irq_clr_i[5] = 1'b1;
        step();
        bus.irq_clr_i[5] = 1'b0;
        check("lvl_reassert", 32'(bus.irq_pending_o[5]), 32'h1);
        bus.irq_en_i[5] = 1'b0;
        steps(3);
        check("en0_keep", 32'(bus.irq_pending_o[5]), 32'h1);
        bus.irq_clr_i[5] = 1'b1;
        step();
        bus.irq_clr_i[5] = 1'b0;
        steps(3);
        check("en0_noset", 32'(bus.irq_pending_o[5]), 32'h0);
        bus.irq_en_i[5] = 1'b1;
        bus.pad_c_i[5]  = 1'b0;
        set_type(5, 2'b00);
        steps(4);
        clear_all();

        // Set/clear collision on pin 2: rise lands on the third edge.
        bus.pad_c_i[2] = 1'b1;
        steps(2);
        bus.irq_clr_i[2] = 1'b1;
        step();
        bus.irq_clr_i[2] = 1'b0;
        check("coll_set_wins", 32'(bus.irq_pending_o[2]), 32'h1);
        bus.irq_clr_i[2] = 1'b1;
        step();
        bus.irq_clr_i[2] = 1'b0;
        check("coll_clr_later", 32'(bus.irq_pending_o[2]), 32'h0);
        bus.pad_c_i[2] = 1'b0;
        steps(3);
        clear_all();

        // Input enable low on pin 7 freezes the filter and events.
        set_type(7, 2'b10);
        bus.pad_ie_i[7] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.pad_c_i[7] = ~bus.pad_c_i[7];
            step();
            if (bus.gpio_in_o[7] || bus.irq_pending_o[7]) seen = 1'b1;
        end
        check("ie0_hold", 32'(seen), 32'h0);
        bus.pad_c_i[7] = 1'b1;
        steps(2);
        bus.pad_ie_i[7] = 1'b1;
        step();
        check("ie_reen_gpio", 32'(bus.gpio_in_o[7]), 32'h1);
        check("ie_reen_pend", 32'(bus.irq_pending_o[7]), 32'h1);
        bus.pad_c_i[7] = 1'b0;
        steps(3);
        clear_all();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) begin
                bus.filt_en_i        = NP'($urandom);
                bus.debounce_limit_i = CW'($urandom_range(0, 6));
                bus.irq_type_i       = (2*NP)'($urandom);
                bus.irq_en_i         = NP'($urandom);
                bus.pad_ie_i         = NP'($urandom | $urandom);
            end
            bus.pad_c_i   = bus.pad_c_i ^ NP'($urandom & $urandom);
            bus.irq_clr_i = NP'($urandom & $urandom & $urandom);
            step();
        end
        bus.irq_clr_i = '0;

        // Async reset mid-count with flags pending.
        bus.pad_ie_i   = '1;
        bus.irq_en_i   = '1;
        bus.irq_type_i = '0;
        bus.filt_en_i  = '0;
        bus.pad_c_i    = '0;
        steps(4);
        bus.pad_c_i = '1;
        steps(4);
        bus.filt_en_i        = '1;
        bus.debounce_limit_i = 8'd50;
        bus.pad_c_i          = '0;
        steps(5);
        check("pre_arst_irq", 32'(bus.irq_o), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gpio", 32'(bus.gpio_in_o), 32'h0);
        check("arst_pend", 32'(bus.irq_pending_o), 32'h0);
        check("arst_irq", 32'(bus.irq_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.irq_type_i = {NP{2'b01}};
        steps(6);
        check("post_arst_nofall", 32'(bus.irq_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
